// File: rtl/pyrxacl_pkg.sv
// ---------------------------------------------------------------------------
// pyrxacl_pkg
// Shared definitions for the RX ACL ping-pong payload buffer and its drain
// sequencer: drain state encoding, the release address, and helpers that turn
// a payload byte length into word-level quantities.
// ---------------------------------------------------------------------------
package pyrxacl_pkg;

    localparam int PKG_ADDR_W = 8;   // 256 x 32-bit words per bank
    localparam int PKG_LEN_W  = 10;  // payload byte length

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        RD   = 3'd2,
        CAP  = 3'd3,
        PRES = 3'd4,
        REL  = 3'd5,
        DONE = 3'd6
    } drain_state_e;

    // Highest word address: always at or above the buffer's end address,
    // so presenting it with a consume pulse releases the bank for any length.
    localparam logic [PKG_ADDR_W-1:0] REL_ADDR = 8'hFF;

    // Index of the last word, ceil(len/4)-1. For len==0 the subtraction wraps
    // to 8'hFF, which is the end address the buffer uses for an empty bank.
    function automatic logic [PKG_ADDR_W-1:0] last_word_idx(input logic [PKG_LEN_W-1:0] len);
        logic [PKG_LEN_W-1:0] len_m1;
        len_m1 = len - 10'd1;
        return len_m1[PKG_LEN_W-1:2];
    endfunction

    // Valid bytes carried by the last word: 1..4.
    function automatic logic [2:0] last_word_bytes(input logic [PKG_LEN_W-1:0] len);
        logic [2:0] nb;
        if (len[1:0] == 2'd0) begin
            nb = 3'd4;
        end else begin
            nb = {1'b0, len[1:0]};
        end
        return nb;
    endfunction

endpackage

// File: rtl/pyrxaclbuf_wordhold.sv
// ---------------------------------------------------------------------------
// pyrxaclbuf_wordhold
// Output hold stage of the RX ACL drain: a 32-bit word plus its last/nbytes
// qualifiers, presented on a valid/ready stream and kept stable while stalled.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load_i          capture din_i/last_i/nbytes_i and raise valid
//   drop_i          withdraw the presented word without a handshake
//   din_i           word to present
//   last_i          word is the final one of the packet
//   nbytes_i        valid bytes in the word
//   ready_i         downstream accepts the word
//   data_o, valid_o, last_o, nbytes_o   registered stream outputs
// ---------------------------------------------------------------------------
module pyrxaclbuf_wordhold (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        drop_i,
    input  logic [31:0] din_i,
    input  logic        last_i,
    input  logic [2:0]  nbytes_i,
    input  logic        ready_i,
    output logic [31:0] data_o,
    output logic        valid_o,
    output logic        last_o,
    output logic [2:0]  nbytes_o
);

    logic [31:0] data_d,   data_q;
    logic        valid_d,  valid_q;
    logic        last_d,   last_q;
    logic [2:0]  nbytes_d, nbytes_q;

    // Next-state of the hold register: load, clear on accept/drop, else hold.
    always_comb begin
        data_d   = data_q;
        valid_d  = valid_q;
        last_d   = last_q;
        nbytes_d = nbytes_q;
        if (load_i) begin
            data_d   = din_i;
            valid_d  = 1'b1;
            last_d   = last_i;
            nbytes_d = nbytes_i;
        end else if (valid_q && (ready_i || drop_i)) begin
            // Qualifiers return to zero so last/nbytes never linger without valid.
            data_d   = 32'h0000_0000;
            valid_d  = 1'b0;
            last_d   = 1'b0;
            nbytes_d = 3'd0;
        end else begin
            data_d   = data_q;
            valid_d  = valid_q;
            last_d   = last_q;
            nbytes_d = nbytes_q;
        end
    end

    // Hold register flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= 32'h0000_0000;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            nbytes_q <= 3'd0;
        end else begin
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            nbytes_q <= nbytes_d;
        end
    end

    assign data_o   = data_q;
    assign valid_o  = valid_q;
    assign last_o   = last_q;
    assign nbytes_o = nbytes_q;

endmodule

// File: rtl/pyrxaclbuf_drain.sv
// ---------------------------------------------------------------------------
// pyrxaclbuf_drain
// Read-side sequencer for the RX ACL ping-pong payload buffer. Walks the
// readable bank word by word, presents each word on a valid/ready stream and
// issues consume pulses so the buffer releases and swaps banks. A flush
// request abandons the rest of the packet and releases the bank directly.
//
// Ports:
//   clk_6M, rstz         clock, asynchronous active-low reset
//   regi_aclrxbufempty   buffer empty flag (1 = nothing readable)
//   rx_lenByte           byte length of the readable bank
//   regi_rxdrain_en      enable; 0 keeps the block idle between packets
//   regi_rxflush_p       single-cycle request to drop the current packet
//   bsm_dout             buffer read data, valid the cycle after bsm_cs
//   bsm_addr, bsm_cs     buffer read address / strobe
//   bsm_valid_p          word-consumed pulse toward the buffer
//   host_*               word stream toward the host side
//   drain_busy           high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module pyrxaclbuf_drain
    import pyrxacl_pkg::*;
#(
    parameter int ADDR_W = PKG_ADDR_W,
    parameter int LEN_W  = PKG_LEN_W
) (
    input  logic              clk_6M,
    input  logic              rstz,
    input  logic              regi_aclrxbufempty,
    input  logic [LEN_W-1:0]  rx_lenByte,
    input  logic              regi_rxdrain_en,
    input  logic              regi_rxflush_p,
    input  logic [31:0]       bsm_dout,
    output logic [ADDR_W-1:0] bsm_addr,
    output logic              bsm_cs,
    output logic              bsm_valid_p,
    output logic [31:0]       host_data,
    output logic              host_valid,
    input  logic              host_ready,
    output logic              host_last,
    output logic [2:0]        host_nbytes,
    output logic              drain_busy
);

    drain_state_e      state_d, state_q;
    logic [ADDR_W-1:0] addr_d,  addr_q;
    logic [LEN_W-1:0]  len_d,   len_q;
    logic              cs_d,    cs_q;
    logic              rel_d,   rel_q;
    logic              busy_d,  busy_q;

    logic              load_s;
    logic              drop_s;
    logic              handshake_s;
    logic              is_last_s;
    logic [2:0]        nbytes_s;

    assign handshake_s = host_valid && host_ready;
    assign is_last_s   = (addr_q == last_word_idx(len_q));
    assign nbytes_s    = is_last_s ? last_word_bytes(len_q) : 3'd4;

    // Sequencer next-state: address walk, release decision and flush handling.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        load_s  = 1'b0;
        drop_s  = 1'b0;
        case (state_q)
            IDLE: begin
                addr_d = {ADDR_W{1'b0}};
                if (regi_rxdrain_en && !regi_aclrxbufempty) begin
                    state_d = LEN;
                end else begin
                    state_d = IDLE;
                end
            end
            LEN: begin
                len_d = rx_lenByte;
                if (regi_rxflush_p || (rx_lenByte == {LEN_W{1'b0}})) begin
                    addr_d  = REL_ADDR;
                    state_d = REL;
                end else begin
                    addr_d  = {ADDR_W{1'b0}};
                    state_d = RD;
                end
            end
            RD: begin
                if (regi_rxflush_p) begin
                    addr_d  = REL_ADDR;
                    state_d = REL;
                end else begin
                    state_d = CAP;
                end
            end
            CAP: begin
                if (regi_rxflush_p) begin
                    addr_d  = REL_ADDR;
                    state_d = REL;
                end else begin
                    load_s  = 1'b1;
                    state_d = PRES;
                end
            end
            PRES: begin
                // An accepted word takes priority over a coincident flush.
                if (handshake_s) begin
                    if (host_last) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = RD;
                    end
                end else if (regi_rxflush_p) begin
                    drop_s  = 1'b1;
                    addr_d  = REL_ADDR;
                    state_d = REL;
                end else begin
                    state_d = PRES;
                end
            end
            REL: begin
                state_d = DONE;
            end
            DONE: begin
                // The empty flag lags the consume pulse by a cycle; waiting for
                // it to rise keeps the stale "not empty" from re-triggering.
                if (regi_aclrxbufempty) begin
                    addr_d  = {ADDR_W{1'b0}};
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                addr_d  = {ADDR_W{1'b0}};
                state_d = IDLE;
            end
        endcase
        cs_d   = (state_d == RD);
        rel_d  = (state_d == REL);
        busy_d = (state_d != IDLE);
    end

    // Sequencer state and registered buffer-side controls.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            state_q <= IDLE;
            addr_q  <= {ADDR_W{1'b0}};
            len_q   <= {LEN_W{1'b0}};
            cs_q    <= 1'b0;
            rel_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cs_q    <= cs_d;
            rel_q   <= rel_d;
            busy_q  <= busy_d;
        end
    end

    pyrxaclbuf_wordhold u_wordhold (
        .clk      (clk_6M),
        .rst_n    (rstz),
        .load_i   (load_s),
        .drop_i   (drop_s),
        .din_i    (bsm_dout),
        .last_i   (is_last_s),
        .nbytes_i (nbytes_s),
        .ready_i  (host_ready),
        .data_o   (host_data),
        .valid_o  (host_valid),
        .last_o   (host_last),
        .nbytes_o (host_nbytes)
    );

    // The consume pulse must coincide with the accepting cycle while bsm_addr
    // still points at that word, so the handshake term is not registered.
    assign bsm_valid_p = rel_q || handshake_s;
    assign bsm_addr    = addr_q;
    assign bsm_cs      = cs_q;
    assign drain_busy  = busy_q;

endmodule

// File: tb/tb_pyrxaclbuf_drain.sv
// ---------------------------------------------------------------------------
// tb_pyrxaclbuf_drain
// Directed bench: a small ping-pong buffer model feeds the drain sequencer,
// a transaction-level model predicts every presented word and consume pulse,
// and each scenario closes with hand-computed totals.
// ---------------------------------------------------------------------------
module tb_pyrxaclbuf_drain;

    logic        clk_6M = 1'b0;
    logic        rstz;
    logic        bufempty = 1'b1;
    logic [9:0]  rx_len;
    logic        en;
    logic        flush;
    logic [31:0] bsm_dout = 32'h0;
    logic [7:0]  bsm_addr;
    logic        bsm_cs;
    logic        bsm_valid_p;
    logic [31:0] host_data;
    logic        host_valid;
    logic        host_ready;
    logic        host_last;
    logic [2:0]  host_nbytes;
    logic        drain_busy;

    int checks = 0;
    int errors = 0;

    // buffer model state
    logic [9:0] plan_len [0:15];
    int pushed = 0;
    int popped = 0;

    // transaction model / monitor state
    int   cyc = 0, mpkt = 0, mword = 0;
    bit   flush_pend = 0, prev_stall = 0, prev_flush = 0, prev_empty = 1, lat_armed = 0;
    logic [31:0] prev_data;
    logic [3:0]  prev_ln;
    int   n_vp = 0, n_words = 0, n_rel = 0, n_hv = 0;
    int   last_nb = 0, last_addr = 0, fall_cyc = 0, lat = 0;
    int   len_i, lwi, exp_nb;
    bit   hs;

    // snapshots
    int w0, v0, r0, h0;

    pyrxaclbuf_drain dut (
        .clk_6M             (clk_6M),
        .rstz               (rstz),
        .regi_aclrxbufempty (bufempty),
        .rx_lenByte         (rx_len),
        .regi_rxdrain_en    (en),
        .regi_rxflush_p     (flush),
        .bsm_dout           (bsm_dout),
        .bsm_addr           (bsm_addr),
        .bsm_cs             (bsm_cs),
        .bsm_valid_p        (bsm_valid_p),
        .host_data          (host_data),
        .host_valid         (host_valid),
        .host_ready         (host_ready),
        .host_last          (host_last),
        .host_nbytes        (host_nbytes),
        .drain_busy         (drain_busy)
    );

    always #5 clk_6M = ~clk_6M;

    function automatic logic [31:0] word_of(input int bank, input int addr);
        logic [7:0] b;
        logic [7:0] a;
        b = bank[7:0];
        a = addr[7:0];
        return {8'hB0 + b, 8'h3C, a, ~a};
    endfunction

    function automatic int end_addr(input int len);
        int nw;
        nw = (len + 3) / 4;
        return (nw == 0) ? 255 : nw - 1;
    endfunction

    assign rx_len = (pushed > popped) ? plan_len[popped[3:0]] : 10'd0;

    // Ping-pong buffer model: registered read data, release on a consume pulse
    // at or above the end address, empty flag updating a cycle later.
    always @(posedge clk_6M) begin
        if (bsm_cs) bsm_dout <= word_of(popped, int'(bsm_addr));
        if (bsm_valid_p && (pushed > popped) &&
            (int'(bsm_addr) >= end_addr(int'(plan_len[popped[3:0]])))) begin
            popped   <= popped + 1;
            bufempty <= 1'b1;
        end else begin
            bufempty <= (pushed == popped);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [9:0] len);
        plan_len[pushed[3:0]] = len;
        pushed++;
    endtask

    task automatic wait_valid(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk_6M); #1;
            if (host_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk(nm, 0, 1);
    endtask

    task automatic wait_idle(input int bound, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk_6M); #1;
            if (!drain_busy && (pushed == popped)) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, int'(ok), 1);
    endtask

    task automatic snap();
        w0 = n_words; v0 = n_vp; r0 = n_rel; h0 = n_hv;
    endtask

    initial begin
        rstz = 1'b0; en = 1'b0; flush = 1'b0; host_ready = 1'b0;

        // Per-cycle compare against the transaction model.
        fork
            forever begin
                @(negedge clk_6M);
                cyc++;
                if (!rstz) begin
                    mword = 0; flush_pend = 0; prev_stall = 0; prev_flush = 0; lat_armed = 0;
                end else begin
                    hs = host_valid && host_ready;
                    if (prev_stall && !prev_flush) begin
                        chk("hold_valid", int'(host_valid), 1);
                        chk("hold_data", int'(host_data), int'(prev_data));
                        chk("hold_last_nbytes", int'({host_last, host_nbytes}), int'(prev_ln));
                    end
                    if (prev_flush) chk("flush_drops_valid", int'(host_valid), 0);
                    if (bsm_cs) chk("read_addr", int'(bsm_addr), mword);
                    if (hs) begin
                        len_i  = int'(plan_len[mpkt[3:0]]);
                        lwi    = (len_i + 3) / 4 - 1;
                        exp_nb = (mword == lwi) ? (((len_i % 4) == 0) ? 4 : len_i % 4) : 4;
                        chk("consume_on_handshake", int'(bsm_valid_p), 1);
                        chk("word_addr", int'(bsm_addr), mword);
                        chk("word_data", int'(host_data), int'(word_of(mpkt, mword)));
                        chk("word_last", int'(host_last), int'(mword == lwi));
                        chk("word_nbytes", int'(host_nbytes), exp_nb);
                        n_words++; n_vp++;
                        last_nb = int'(host_nbytes); last_addr = int'(bsm_addr);
                        if (mword == lwi) begin
                            mpkt++; mword = 0;
                        end else begin
                            mword++;
                        end
                    end else if (bsm_valid_p) begin
                        chk("release_addr", int'(bsm_addr), 255);
                        chk("release_no_valid", int'(host_valid), 0);
                        chk("release_allowed",
                            int'((plan_len[mpkt[3:0]] == 10'd0) || flush_pend), 1);
                        n_vp++; n_rel++; mpkt++; mword = 0; flush_pend = 0;
                    end
                    if (host_valid) n_hv++;
                    if (flush && host_valid && !host_ready) flush_pend = 1;
                    prev_flush = flush && host_valid && !host_ready;
                    prev_stall = host_valid && !host_ready;
                    prev_data  = host_data;
                    prev_ln    = {host_last, host_nbytes};
                    if (prev_empty && !bufempty) begin
                        fall_cyc = cyc; lat_armed = 1;
                    end
                    if (lat_armed && host_valid) begin
                        lat = cyc - fall_cyc; lat_armed = 0;
                    end
                end
                prev_empty = bufempty;
            end
        join_none

        repeat (3) @(posedge clk_6M);
        #1;
        chk("reset_data", int'(host_data), 0);
        chk("reset_ctl", int'({bsm_addr, bsm_cs, bsm_valid_p, host_valid, host_last,
                               host_nbytes, drain_busy}), 0);
        rstz = 1'b1;
        @(posedge clk_6M); #1;
        en = 1'b1; host_ready = 1'b1;

        // len=9, always ready: 3 words, last carries 1 byte
        snap(); push(10'd9);
        wait_idle(200, "s1_idle");
        chk("s1_latency", lat, 4);
        chk("s1_words", n_words - w0, 3);
        chk("s1_consumes", n_vp - v0, 3);
        chk("s1_last_nbytes", last_nb, 1);
        chk("s1_last_addr", last_addr, 2);

        // len=8, 5-cycle stall on word 1
        snap(); host_ready = 1'b0; push(10'd8);
        wait_valid("s2_word0_timeout");
        host_ready = 1'b1;
        @(posedge clk_6M); #1;
        host_ready = 1'b0;
        wait_valid("s2_word1_timeout");
        repeat (5) @(posedge clk_6M);
        #1;
        chk("s2_no_consume_while_stalled", n_vp - v0, 1);
        chk("s2_still_valid", int'(host_valid), 1);
        host_ready = 1'b1;
        wait_idle(200, "s2_idle");
        chk("s2_words", n_words - w0, 2);
        chk("s2_last_nbytes", last_nb, 4);
        chk("s2_last_addr", last_addr, 1);

        // len=0: release only
        snap(); push(10'd0);
        wait_idle(200, "s3_idle");
        chk("s3_consumes", n_vp - v0, 1);
        chk("s3_releases", n_rel - r0, 1);
        chk("s3_no_valid", n_hv - h0, 0);

        // len=1023: full bank, no wrap
        snap(); push(10'd1023);
        wait_idle(2000, "s4_idle");
        chk("s4_words", n_words - w0, 256);
        chk("s4_last_nbytes", last_nb, 3);
        chk("s4_last_addr", last_addr, 255);

        // len=40, flush while word 3 is stalled
        snap(); host_ready = 1'b0; push(10'd40);
        for (int k = 0; k < 3; k++) begin
            wait_valid("s5_word_timeout");
            host_ready = 1'b1;
            @(posedge clk_6M); #1;
            host_ready = 1'b0;
        end
        wait_valid("s5_word3_timeout");
        flush = 1'b1;
        @(posedge clk_6M); #1;
        flush = 1'b0;
        chk("s5_valid_dropped", int'(host_valid), 0);
        chk("s5_release_pulse", int'(bsm_valid_p), 1);
        chk("s5_release_addr", int'(bsm_addr), 255);
        wait_idle(200, "s5_idle");
        chk("s5_words", n_words - w0, 3);
        chk("s5_releases", n_rel - r0, 1);
        host_ready = 1'b1;

        // enable low keeps the block idle with data pending
        snap(); en = 1'b0; push(10'd4);
        repeat (10) @(posedge clk_6M);
        #1;
        chk("s6_idle_disabled", int'(drain_busy), 0);
        chk("s6_no_valid", n_hv - h0, 0);
        en = 1'b1;
        wait_idle(200, "s6_idle");
        chk("s6_words", n_words - w0, 1);

        // both banks full, reset in the middle of the second packet
        snap(); push(10'd5); push(10'd12);
        begin
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 300; i++) begin
                @(posedge clk_6M); #1;
                if (n_words - w0 >= 3) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("s7_reach_second_packet", int'(ok), 1);
        end
        chk("s7_first_packet_released", popped, pushed - 1);
        rstz = 1'b0;
        #1;
        chk("s7_reset_data", int'(host_data), 0);
        chk("s7_reset_ctl", int'({bsm_addr, bsm_cs, bsm_valid_p, host_valid, host_last,
                                  host_nbytes, drain_busy}), 0);
        repeat (2) @(posedge clk_6M);
        #1;
        rstz = 1'b1;
        snap();
        wait_idle(300, "s7_idle");
        chk("s7_restart_words", n_words - w0, 3);
        chk("s7_last_nbytes", last_nb, 4);
        chk("s7_last_addr", last_addr, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
